// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 keyboard frame receiver with glitch-filtered clock
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_frame_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       pixelClk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       rxErr,
    output logic       rxBusy
);
    localparam int FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rxStateT;

    logic [1:0]       clkSync;
    logic [1:0]       dataSync;
    logic             syncClk;
    logic             syncData;
    logic             filtClk;
    logic [FiltW-1:0] filtCnt;
    logic             sampleStb;
    rxStateT          state;
    rxStateT          stateNext;
    logic [2:0]       bitCnt;
    logic [2:0]       bitCntNext;
    logic [7:0]       shiftReg;
    logic [7:0]       shiftNext;
    logic             parityBit;
    logic             parityNext;
    logic             validNext;
    logic             errNext;
    logic             loadByte;
    logic             timeout;

    assign syncClk  = clkSync[1];
    assign syncData = dataSync[1];
    assign rxBusy   = (state != IDLE);

    // Synchronizers reset high so an idle bus is seen during and after reset
    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], ps2Clk};
            dataSync <= {dataSync[0], ps2Data};
        end
    end

    // Filtered clock follows syncClk only after FILTER_LEN agreeing samples;
    // the strobe lands in the cycle after a filtered 1->0 transition.
    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            filtClk   <= 1'b1;
            filtCnt   <= '0;
            sampleStb <= 1'b0;
        end else begin
            sampleStb <= 1'b0;
            if (syncClk == filtClk) begin
                filtCnt <= '0;
            end else if (filtCnt == FiltW'(FILTER_LEN - 1)) begin
                filtClk   <= syncClk;
                filtCnt   <= '0;
                sampleStb <= ~syncClk;
            end else begin
                filtCnt <= filtCnt + 1'b1;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    logic [31:0] wdCnt;

    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            wdCnt <= '0;
        end else if (state == IDLE || sampleStb) begin
            wdCnt <= '0;
        end else begin
            wdCnt <= wdCnt + 32'd1;
        end
    end

    // A coinciding sample event takes priority over expiry
    assign timeout = (state != IDLE) && !sampleStb && (wdCnt == 32'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        parityNext = parityBit;
        validNext  = 1'b0;
        errNext    = 1'b0;
        loadByte   = 1'b0;
        if (timeout) begin
            stateNext = IDLE;
            errNext   = 1'b1;
        end else if (sampleStb) begin
            case (state)
                IDLE: begin
                    if (!syncData) begin
                        stateNext  = DATA;
                        bitCntNext = 3'd0;
                    end
                end
                DATA: begin
                    shiftNext  = {syncData, shiftReg[7:1]};
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        stateNext = PARITY;
                    end
                end
                PARITY: begin
                    parityNext = syncData;
                    stateNext  = STOP;
                end
                STOP: begin
                    stateNext = IDLE;
                    // Odd parity over data plus parity bit
                    if (syncData && (^{shiftReg, parityBit})) begin
                        validNext = 1'b1;
                        loadByte  = 1'b1;
                    end else begin
                        errNext = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bitCnt    <= 3'd0;
            shiftReg  <= 8'h00;
            parityBit <= 1'b0;
            rxByte    <= 8'h00;
            rxValid   <= 1'b0;
            rxErr     <= 1'b0;
        end else begin
            state     <= stateNext;
            bitCnt    <= bitCntNext;
            shiftReg  <= shiftNext;
            parityBit <= parityNext;
            rxValid   <= validNext;
            rxErr     <= errNext;
            if (loadByte) begin
                rxByte <= shiftReg;
            end
        end
    end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb/tb_ps2_frame_rx.sv - scoreboard bench for ps2_frame_rx
module tb_ps2_frame_rx;
    localparam int HALF = 20;
    localparam int TO   = 500;

    logic       pixelClk = 1'b0;
    logic       reset    = 1'b0;
    logic       ps2Clk   = 1'b1;
    logic       ps2Data  = 1'b1;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       rxErr;
    logic       rxBusy;

    ps2_frame_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
        .pixelClk (pixelClk),
        .reset    (reset),
        .ps2Clk   (ps2Clk),
        .ps2Data  (ps2Data),
        .rxByte   (rxByte),
        .rxValid  (rxValid),
        .rxErr    (rxErr),
        .rxBusy   (rxBusy)
    );

    always #5 pixelClk = ~pixelClk;

    typedef struct packed {
        logic       isErr;
        logic [7:0] b;
    } expT;

    expT        q[$];
    int         errors    = 0;
    int         checks    = 0;
    int         cycleCnt  = 0;
    int         errCycle  = -1;
    int         lastFall  = 0;
    logic [7:0] lastGood  = 8'h00;

    always @(posedge pixelClk) cycleCnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge pixelClk) begin
        if (reset && (rxValid || rxErr)) begin
            check("pulse_exclusive", 32'(rxValid & rxErr), 32'd0);
            if (q.size() == 0) begin
                check("unexpected_pulse", 32'({rxValid, rxErr}), 32'd0);
            end else begin
                expT e;
                e = q.pop_front();
                check("pulse_kind_err", 32'(rxErr), 32'(e.isErr));
                check("pulse_rx_byte", 32'(rxByte), 32'(e.b));
                if (rxErr) errCycle = cycleCnt;
            end
        end
    end

    task automatic waitCyc(input int n);
        repeat (n) @(negedge pixelClk);
    endtask

    function automatic logic [10:0] mkFrame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2Data = bits[i];
            waitCyc(HALF);
            ps2Clk   = 1'b0;
            lastFall = cycleCnt;
            waitCyc(HALF);
            ps2Clk = 1'b1;
        end
        waitCyc(HALF);
        ps2Data = 1'b1;
    endtask

    task automatic waitDrain(input string tag, input int maxCyc);
        for (int i = 0; i < maxCyc && q.size() != 0; i++) waitCyc(1);
        waitCyc(3);
        check(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic sendGood(input logic [7:0] d);
        q.push_back({1'b0, d});
        lastGood = d;
        sendBits(mkFrame(d, ~^d, 1'b1), 11);
        waitDrain("drain_good", 100);
    endtask

    task automatic sendBad(input logic [7:0] d, input logic par, input logic stop);
        q.push_back({1'b1, lastGood});
        sendBits(mkFrame(d, par, stop), 11);
        waitDrain("drain_bad", 100);
    endtask

    initial begin
        waitCyc(3);
        check("reset_rxByte", 32'(rxByte), 32'h00);
        check("reset_rxValid", 32'(rxValid), 32'd0);
        check("reset_rxErr", 32'(rxErr), 32'd0);
        check("reset_rxBusy", 32'(rxBusy), 32'd0);
        reset = 1'b1;
        waitCyc(5);

        sendGood(8'h1C);
        check("hold_1c", 32'(rxByte), 32'h1C);
        sendBad(8'hF0, 1'b0, 1'b1);
        check("after_parity_err", 32'(rxByte), 32'h1C);
        sendBad(8'h1C, 1'b0, 1'b0);
        check("after_stop_err", 32'(rxByte), 32'h1C);
        sendGood(8'h00);
        sendGood(8'hFF);
        sendGood(8'hA5);

        // 3-cycle low glitch must be filtered out
        ps2Clk = 1'b0;
        waitCyc(3);
        ps2Clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            waitCyc(1);
            check("glitch_busy", 32'(rxBusy), 32'd0);
        end
        check("glitch_byte", 32'(rxByte), 32'hA5);

`ifdef PS2_RX_TIMEOUT_EN
        q.push_back({1'b1, lastGood});
        errCycle = -1;
        sendBits(mkFrame(8'h3C, 1'b1, 1'b1), 5);
        check("stall_busy", 32'(rxBusy), 32'd1);
        waitDrain("drain_timeout", TO + 100);
        check("timeout_latency", 32'((errCycle - lastFall >= TO) && (errCycle - lastFall <= TO + 20)), 32'd1);
        check("timeout_busy_low", 32'(rxBusy), 32'd0);
`endif
        sendGood(8'h29);
        check("hold_29", 32'(rxByte), 32'h29);

        // Reset in the middle of a frame: start + 5 data bits
        sendBits(mkFrame(8'h33, 1'b1, 1'b1), 6);
        check("midframe_busy", 32'(rxBusy), 32'd1);
        @(negedge pixelClk);
        #2 reset = 1'b0;
        #1;
        check("midreset_rxByte", 32'(rxByte), 32'h00);
        check("midreset_rxValid", 32'(rxValid), 32'd0);
        check("midreset_rxErr", 32'(rxErr), 32'd0);
        check("midreset_rxBusy", 32'(rxBusy), 32'd0);
        waitCyc(5);
        reset    = 1'b1;
        lastGood = 8'h00;
        waitCyc(20);
        check("postreset_busy", 32'(rxBusy), 32'd0);
        sendGood(8'h5A);
        check("hold_5a", 32'(rxByte), 32'h5A);

        waitCyc(50);
        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synced ps2Clk samples required before the filtered clock changes.
REQ-002 Parameter TIMEOUT_CYC, default 50000: pixelClk cycles without a sample event before a frame is aborted (2 ms at 25 MHz).
REQ-003 pixelClk  input  1  sole clock, all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-low; assertion takes effect immediately, release synchronous to pixelClk.
REQ-005 ps2Clk  input  1  raw PS/2 clock from keyboard, asynchronous to pixelClk.
REQ-006 ps2Data  input  1  raw PS/2 data from keyboard, asynchronous to pixelClk.
REQ-007 rxByte  output  8  last correctly received scan-code byte.
REQ-008 rxValid  output  1  one-cycle pulse, rxByte newly updated.
REQ-009 rxErr  output  1  one-cycle pulse, frame rejected (start/parity/stop/timeout).
REQ-010 rxBusy  output  1  high while a frame is in progress.

Function
REQ-011 ps2Clk and ps2Data each pass through a 2-flop synchronizer before any use.
REQ-012 Filtered clock changes level only after FILTER_LEN consecutive synced samples at the new level; shorter pulses are ignored.
REQ-013 A sample event is a 1-cycle strobe in the cycle after the filtered clock goes 1->0; synced ps2Data is captured in that cycle.
REQ-014 States: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: sample with data=0 -> DATA, bit counter=0; sample with data=1 -> stay IDLE, no error.
REQ-016 DATA: shift data in LSB first; after 8th sample -> PARITY.
REQ-017 PARITY: capture parity bit -> STOP.
REQ-018 STOP: on sample, if stop bit=1 and the 9 bits (data+parity) have odd count of ones -> rxByte loaded, rxValid=1 next cycle; otherwise rxErr=1 next cycle, rxByte unchanged; both cases -> IDLE.
REQ-019 rxValid and rxErr are never asserted in the same cycle and each lasts exactly one cycle.
REQ-020 rxByte holds its value until the next valid frame.
REQ-021 rxBusy=1 exactly when state is DATA, PARITY or STOP.
REQ-022 ps2Data is never driven; receive-only block.

Reset
REQ-023 Reset asserted: state IDLE, rxByte=0x00, rxValid=0, rxErr=0, rxBusy=0, bit counter and filter counter 0, synchronizers and filtered clock set to 1 (idle bus).
REQ-024 Reset mid-frame discards partial data; no rxValid or rxErr is produced for the aborted frame.

Configuration
REQ-025 Macro PS2_RX_TIMEOUT_EN defined: a watchdog counter clears on every sample event and in IDLE, increments otherwise; on reaching TIMEOUT_CYC the state returns to IDLE, partial data is discarded, and rxErr pulses for one cycle.
REQ-026 If a sample event and timeout coincide, the sample event wins and the counter clears.
REQ-027 Macro undefined: no watchdog logic; a stalled frame waits indefinitely for further edges; TIMEOUT_CYC is unused.

Verification
REQ-028 Frame start0, 0x1C LSB-first, parity 0, stop 1 -> single rxValid pulse, rxByte=0x1C, rxErr stays 0.
REQ-029 Frame 0xF0 with parity 0 (wrong) -> rxErr pulse, no rxValid, rxByte stays 0x1C.
REQ-030 Frame 0x1C, parity correct, stop bit 0 -> rxErr pulse, rxByte unchanged.
REQ-031 3-cycle low glitch on ps2Clk in IDLE (FILTER_LEN=8) -> no sample event, rxBusy stays 0, no pulses.
REQ-032 With PS2_RX_TIMEOUT_EN: start bit + 4 data bits, then ps2Clk held high -> rxErr pulse TIMEOUT_CYC cycles after last sample, rxBusy falls; following 0x29 frame -> rxValid, rxByte=0x29.
REQ-033 Reset pulsed low after 5th data bit -> all outputs 0 immediately, no pulse; after release, frame 0x5A -> rxValid, rxByte=0x5A.
